// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid/ready handshake, optional skid
// entry for a registered in_ready, synchronous flush and saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 8,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID_FULL} state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                in_fire, out_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    // With the skid entry present, in_ready never sees out_ready.
    if (SKID) in_ready = (state_q != SKID_FULL) & ~flush;
    else      in_ready = (~out_valid | out_ready) & ~flush;
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;

    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d     = FULL;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            state_d     = SKID_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        SKID_FULL: if (out_fire) begin
          state_d     = FULL;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
        default: state_d = EMPTY;
      endcase
    end

    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);

    // Bubble gating keeps stale or unknown control off the output.
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    out_data  = main_data_q;
    stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a default SKID=1 stage, a CNT_W=4 twin sharing its inputs,
// and a SKID=0 stage with its own inputs.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [47:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [7:0]  out_ctrl;
  logic [47:0] out_data;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_ctrl;
  logic [47:0] s_out_data;
  logic [3:0]  s_stall_cnt;

  logic        z_in_valid = 1'b0, z_flush = 1'b0, z_out_ready = 1'b0;
  logic [7:0]  z_in_ctrl = '0;
  logic [47:0] z_in_data = '0;
  logic        z_in_ready, z_out_valid;
  logic [7:0]  z_out_ctrl;
  logic [47:0] z_out_data;
  logic [15:0] z_stall_cnt;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(48), .CTRL_W(8), .SKID(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt));

  pipe_stage_reg #(.DATA_W(48), .CTRL_W(8), .SKID(1'b1), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt));

  pipe_stage_reg #(.DATA_W(48), .CTRL_W(8), .SKID(1'b0), .CNT_W(16)) dut_z (
    .clk(clk), .reset(reset), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_ctrl(z_in_ctrl), .in_data(z_in_data), .flush(z_flush), .out_valid(z_out_valid),
    .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
    .stall_cnt(z_stall_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with live-looking inputs
    in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 48'h0000_1234_5678;
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ctrl",  64'(out_ctrl),  64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    out_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("rel_valid", 64'(out_valid), 64'd1);
    chk("rel_ctrl",  64'(out_ctrl),  64'hFF);
    chk("rel_data",  64'(out_data),  64'h0000_1234_5678);
    in_valid = 1'b0;
    step();
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_ctrl",  64'(out_ctrl),  64'd0);
    chk("bubble_data",  64'(out_data),  64'h0000_1234_5678);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 48'(i); in_ctrl = 8'(i);
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      step();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data",  64'(out_data),  64'(i));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", 64'(out_valid), 64'd0);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Skid: A, B, C with a two-cycle downstream stall
    in_valid = 1'b1; in_data = 48'hA; in_ctrl = 8'h0A;
    step();
    chk("skid_A_out", 64'(out_data), 64'hA);
    out_ready = 1'b0; in_data = 48'hB; in_ctrl = 8'h0B;
    step();
    in_data = 48'hC; in_ctrl = 8'h0C;
    #1;
    chk("skid_in_ready_low", 64'(in_ready), 64'd0);
    chk("skid_hold_A", 64'(out_data), 64'hA);
    chk("skid_stall1", 64'(stall_cnt), 64'd1);
    step();
    chk("skid_hold_A2", 64'(out_data), 64'hA);
    chk("skid_stall2", 64'(stall_cnt), 64'd2);
    out_ready = 1'b1;
    step();
    chk("skid_B_out", 64'(out_data), 64'hB);
    chk("skid_B_ctrl", 64'(out_ctrl), 64'h0B);
    chk("skid_in_ready_back", 64'(in_ready), 64'd1);
    step();
    chk("skid_C_out", 64'(out_data), 64'hC);
    in_valid = 1'b0;
    step();
    chk("skid_drain", 64'(out_valid), 64'd0);
    chk("skid_stall_final", 64'(stall_cnt), 64'd2);

    // Flush from SKID_FULL
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h81; in_data = 48'h111;
    step();
    in_data = 48'h222;
    step();
    chk("flush_pre_ctrl", 64'(out_ctrl), 64'h81);
    flush = 1'b1; in_data = 48'h333; in_ctrl = 8'h3C;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl",  64'(out_ctrl),  64'd0);
    chk("flush_data",  64'(out_data),  64'h111);
    step();
    chk("flush_no_capture", 64'(out_valid), 64'd0);
    chk("flush_stall_kept", 64'(stall_cnt), 64'd4);

    // Saturation: one entry held for 20 stalled cycles
    in_valid = 1'b1; in_data = 48'h55; in_ctrl = 8'h01;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("sat_cnt4", 64'(s_stall_cnt), 64'd15);
    chk("sat_cnt16", 64'(stall_cnt), 64'd24);
    chk("sat_still_valid", 64'(s_out_valid), 64'd1);

    // SKID=0 stage: combinational in_ready
    z_in_valid = 1'b1; z_in_data = 48'h77; z_in_ctrl = 8'h07;
    step();
    z_in_data = 48'h78;
    #1;
    chk("z_full_stall_ready", 64'(z_in_ready), 64'd0);
    z_out_ready = 1'b1;
    #1;
    chk("z_comb_ready", 64'(z_in_ready), 64'd1);
    chk("z_data77", 64'(z_out_data), 64'h77);
    step();
    chk("z_data78", 64'(z_out_data), 64'h78);
    z_in_data = 48'h79;
    step();
    chk("z_data79", 64'(z_out_data), 64'h79);
    chk("z_valid", 64'(z_out_valid), 64'd1);
    z_in_valid = 1'b0;
    step();
    chk("z_drain", 64'(z_out_valid), 64'd0);

    // Asynchronous reset mid-transfer
    in_valid = 1'b1; in_data = 48'h99; in_ctrl = 8'h42; out_ready = 1'b0;
    step();
    chk("mid_loaded", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #2;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data",  64'(out_data),  64'd0);
    chk("mid_rst_stall", 64'(stall_cnt), 64'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register with valid/ready handshake, a 2-entry skid buffer, synchronous flush, and bubble-safe control gating. It is the generic successor to the fixed-field stage registers and sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB). A stalled downstream stage back-pressures upstream without losing a transfer, and a flushed stage emits zeroed control so no spurious write-enables leak.

Parameters:
DATA_W, 48, payload bits; held through bubbles, never cleared except by reset
CTRL_W, 8, control bits such as write-enables and selects; forced to 0 on a bubble or flush
SKID, 1, 1 = registered in_ready via skid entry; 0 = single register with combinational in_ready
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream has a transfer
in_ready  out  1  stage can accept
in_ctrl  in  CTRL_W  upstream control bits
in_data  in  DATA_W  upstream payload
flush  in  1  synchronous kill of stage contents
out_valid  out  1  stage holds a valid transfer
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  control; 0 whenever out_valid = 0
out_data  out  DATA_W  payload of the main entry
stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready

Behaviour:
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Either side may raise valid or ready independently.
- Storage: a main entry (drives the outputs) and a skid entry. The skid entry exists only when SKID = 1.
- States: EMPTY, FULL, SKID_FULL. SKID_FULL is unreachable when SKID = 0.
- Transitions from EMPTY:
  - in_fire -> FULL; main <= in.
- Transitions from FULL:
  - in_fire & out_fire -> FULL; main <= in.
  - in_fire & !out_fire -> SKID_FULL; skid <= in; main unchanged.
  - !in_fire & out_fire -> EMPTY.
  - otherwise hold.
- Transitions from SKID_FULL:
  - out_fire -> FULL; main <= skid.
  - otherwise hold.
  - No input is accepted in this state.
- in_ready:
  - SKID = 1: in_ready = (state != SKID_FULL) & !flush. It depends only on state and flush, with no path from out_ready.
  - SKID = 0: in_ready = (!out_valid | out_ready) & !flush.
- Outputs: out_valid = (state != EMPTY). out_ctrl = out_valid ? main_ctrl : 0. out_data = main_data, always driven, including the stale value while EMPTY.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Throughput is 1 transfer per cycle while out_ready = 1.
- Flush (synchronous, highest priority):
  - Next state EMPTY; main_ctrl and skid_ctrl <= 0; data fields hold.
  - in_ready = 0 during a flush cycle, so no input is captured.
  - An out_fire in the flush cycle still counts as delivered downstream.
  - Flush while EMPTY has no effect.
- stall_cnt: increments each cycle with out_valid & !out_ready. Saturates at 2^CNT_W-1 with no wrap. Not cleared by flush.
- Ordering: transfers leave in acceptance order; the skid entry is never bypassed.
- Reset (asynchronous, active-low):
  - State EMPTY; main, skid and stall_cnt <= 0.
  - out_valid = 0, out_ctrl = 0, out_data = 0, stall_cnt = 0.
  - in_ready = 1 after reset deasserts (0 while flush is high). Inputs are ignored while reset is low.
  - Reset mid-transfer discards both entries with no partial output.
- X-safety: no X may propagate to out_ctrl when EMPTY, whatever the state of in_ctrl.

Test Plan:
- Reset/bubble: assert reset with in_ctrl = 8'hFF, in_valid = 1 -> out_valid = 0, out_ctrl = 0, out_data = 0, stall_cnt = 0; after release with out_ready = 1 -> out_valid = 1 next cycle, out_ctrl = 8'hFF.
- Streaming: out_ready = 1, in_valid = 1 for 8 cycles, data 1..8 -> outputs 1..8 with 1-cycle latency, no gaps, in_ready constantly 1.
- Skid: stream data A, B, C; drop out_ready when A is at the output -> B is captured into skid, in_ready falls the next cycle, C is held upstream; raise out_ready -> A, B, C delivered in order with no loss or duplication; stall_cnt = stalled cycles.
- Flush: state SKID_FULL with ctrl 8'h81 in both entries; pulse flush -> next cycle out_valid = 0, out_ctrl = 0, out_data unchanged; input presented during the flush cycle is not captured.
- Saturation: CNT_W = 4, hold out_valid = 1, out_ready = 0 for 20 cycles -> stall_cnt stops at 15.
- SKID = 0 build: out_ready = 0 with stage FULL -> in_ready = 0 combinationally; out_ready = 1 -> in_ready = 1 in the same cycle, full throughput.
